// File: rtl/md_seq_pkg.sv
// Shared definitions for the md_seq iterative multiply/divide unit:
// operation codes, FSM states, ALU op codes and iteration constants.
package md_seq_pkg;

    // Request operation select.
    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // ALU operation codes.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;

    // One RUN cycle per operand bit.
    localparam int         MD_ITERS     = 32;
    localparam logic [4:0] MD_LAST_ITER = 5'(MD_ITERS - 1);

    // DIVU and REMU share the restoring-division datapath.
    function automatic logic is_div_op(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_seq_alu.sv
// Small 32-bit ALU; md_seq uses only its add and subtract functions.
module alu
    import md_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    // Combinational operation select; unknown op codes yield zero.
    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = 32'd0;
        endcase
        zero = (result == 32'd0);
    end

endmodule

// File: rtl/md_seq.sv
// md_seq: sequential 32-bit unsigned multiply / divide unit.
// One bit per RUN cycle (32 cycles), then a DONE state that registers
// the result and holds it until the consumer takes it.
// Handshakes: a transfer happens on a rising edge where valid && ready
// are both high; valid never depends on ready in the same cycle.
module md_seq
    import md_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    md_state_e   state;
    md_state_e   state_nxt;
    logic [4:0]  cnt;
    md_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] res_q;
    logic        res_vld;

    logic        accept;
    logic        out_fire;
    logic        div_mode;

    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero_unused;

    logic [31:0] mul_sum;
    logic        mul_carry;
    logic [31:0] div_t;
    logic        div_g;
    logic [31:0] result_sel;

    assign accept   = in_valid && (state == ST_IDLE);
    assign out_fire = res_vld && out_ready;
    assign div_mode = is_div_op(op_q);

    // Divide step: shift next dividend bit into the partial remainder.
    // A set rem[31] means the shifted value overflowed 32 bits, so it is
    // certainly >= b and the truncated ALU difference is still correct.
    assign div_t = {rem[30:0], quo[31]};
    assign div_g = rem[31] || !(div_t < b_q);

    // Multiply step: conditional add, carry recovered from wrap-around.
    assign mul_sum   = lo[0] ? alu_y : hi;
    assign mul_carry = lo[0] && (mul_sum < hi);

    // Single ALU shared between the add (multiply) and subtract (divide) paths.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = hi;
        alu_b  = a_q;
        if (div_mode) begin
            alu_op = ALU_SUB;
            alu_a  = div_t;
            alu_b  = b_q;
        end
    end

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_y),
        .zero   (alu_zero_unused)
    );

    // Pick the architectural result for the latched operation.
    always_comb begin
        result_sel = lo;
        case (op_q)
            MD_MUL:   result_sel = lo;
            MD_MULHU: result_sel = hi;
            MD_DIVU:  result_sel = quo;
            MD_REMU:  result_sel = rem;
            default:  result_sel = lo;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == MD_LAST_ITER) state_nxt = ST_DONE;
            ST_DONE: if (out_fire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; the result bus is forced to zero when not valid.
    always_comb begin
        in_ready   = (state == ST_IDLE);
        busy       = (state != ST_IDLE);
        out_valid  = (state == ST_DONE) && res_vld;
        out_result = out_valid ? res_q : 32'd0;
    end

    // Datapath: operand capture, one iteration per RUN cycle, result register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= 5'd0;
            op_q    <= MD_MUL;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            res_q   <= 32'd0;
            res_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= md_op_e'(in_op);
                        a_q     <= in_a;
                        b_q     <= in_b;
                        cnt     <= 5'd0;
                        hi      <= 32'd0;
                        lo      <= in_b;
                        rem     <= 32'd0;
                        quo     <= in_a;
                        res_vld <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 5'd1;
                    if (div_mode) begin
                        rem <= div_g ? alu_y : div_t;
                        quo <= {quo[30:0], div_g};
                    end else begin
                        hi <= {mul_carry, mul_sum[31:1]};
                        lo <= {mul_sum[0], lo[31:1]};
                    end
                end
                ST_DONE: begin
                    if (!res_vld) begin
                        res_q   <= result_sel;
                        res_vld <= 1'b1;
                    end else if (out_fire) begin
                        res_vld <= 1'b0;
                    end
                end
                default: begin
                    res_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: driver pushes hand-computed results and
// accept cycles into queues, a negedge monitor pops and compares.
module tb_md_seq;

    localparam int LATENCY = 33;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_valid = 1'b0;

    md_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one request; returns #1 after its accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int guard = 0;
        @(posedge clk); #1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk); #1;
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    // Wait until every expected result has been consumed and the unit is idle.
    task automatic wait_done();
        int guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: latency on rising out_valid, value on handshake, zero bus when idle.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                else check("latency", 32'(cyc - acc_q.pop_front()), 32'(LATENCY));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", out_result, 32'd0);
                else check("result", out_result, exp_q.pop_front());
            end
            if (!out_valid) check("result_zero_when_idle", out_result, 32'd0);
        end
        prev_valid = out_valid;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed stimulus.
    initial begin
        logic busy_bad;
        resetn    = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_a      = 32'd5;
        in_b      = 32'd5;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        resetn   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("no_accept_in_reset", 32'(busy), 32'd0);

        // MUL 6*7 with busy window.
        issue(2'b00, 32'd6, 32'd7, 32'd42);
        busy_bad = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            @(negedge clk);
            if (!busy || out_valid) busy_bad = 1'b1;
        end
        check("busy_window", 32'(busy_bad), 32'd0);
        @(negedge clk);
        check("valid_at_33", 32'(out_valid), 32'd1);
        wait_done();

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        issue(2'b10, 32'd100, 32'd7, 32'd14);
        issue(2'b11, 32'd100, 32'd7, 32'd2);
        issue(2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000);
        issue(2'b10, 32'd1234, 32'd0, 32'hFFFF_FFFF);
        issue(2'b11, 32'd1234, 32'd0, 32'd1234);
        wait_done();

        // Back-pressure in DONE while toggling in_valid.
        out_ready = 1'b0;
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        for (int g = 0; g < 60 && !out_valid; g++) @(negedge clk);
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = k[0];
            in_op    = 2'b00;
            in_a     = 32'd3;
            in_b     = 32'd3;
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_result_hold", out_result, 32'd1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_hs", 32'(in_ready), 32'd1);
        check("valid_after_hs", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("no_toggle_accept", 32'(busy), 32'd0);
        wait_done();

        // Reset at RUN iteration 10, then REMU 9/4.
        issue(2'b10, 32'd100, 32'd7, 32'd14);
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        acc_q.delete();
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_a     = 32'd77;
        in_b     = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        resetn   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        issue(2'b11, 32'd9, 32'd4, 32'd1);
        wait_done();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
